// File: rtl/rect_fill_engine_if.sv
// rect_fill_engine_if: request/status/pixel-write bundle for rect_fill_engine.
//   master : controller side, drives start/abort/geometry/colour/mode and
//            observes busy/done plus the VGA pixel-write port.
//   slave  : engine side.
//   start, abort        request level and early-termination input
//   x0, y0, w, h        rectangle origin and size (w/h may be 0)
//   colour, mode        base colour and colour mode (0..3)
//   busy, done          status
//   vga_x/y/colour/plot pixel write towards the VGA adapter
interface rect_fill_engine_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic                start;
  logic                abort;
  logic [X_W-1:0]      x0;
  logic [Y_W-1:0]      y0;
  logic [X_W:0]        w;
  logic [Y_W:0]        h;
  logic [COLOUR_W-1:0] colour;
  logic [1:0]          mode;
  logic                busy;
  logic                done;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  modport master (
    output start, abort, x0, y0, w, h, colour, mode,
    input  busy, done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, abort, x0, y0, w, h, colour, mode,
    output busy, done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: plots an axis-aligned rectangle clipped to the screen,
// one pixel per clock, column-major (y fastest), with four colour modes.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rect_fill_engine_if.slave (request, status, VGA pixel port)
// All outputs are registered from the next state, so each output reflects
// the state the engine is in during that cycle.
module rect_fill_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  rect_fill_engine_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILL, S_DONE} state_t;

  localparam logic [X_W+1:0] LP_SW = (X_W+2)'(SCREEN_W);
  localparam logic [Y_W+1:0] LP_SH = (Y_W+2)'(SCREEN_H);

  state_t              r_state;
  state_t              w_next;

  logic [X_W:0]        r_x_end;
  logic [Y_W+1:0]      r_y_end;
  logic [Y_W-1:0]      r_y0;
  logic [COLOUR_W-1:0] r_colour;
  logic [1:0]          r_mode;

  logic                r_busy;
  logic                r_done;
  logic [X_W-1:0]      r_vga_x;
  logic [Y_W-1:0]      r_vga_y;
  logic [COLOUR_W-1:0] r_vga_colour;
  logic                r_vga_plot;

  logic [X_W+1:0]      w_x_sum;
  logic [Y_W+1:0]      w_y_sum;
  logic [X_W:0]        w_x_end_ld;
  logic [Y_W+1:0]      w_y_end_ld;
  logic                w_empty;
  logic [X_W:0]        w_x_inc;
  logic [Y_W+1:0]      w_y_inc;
  logic                w_y_wrap;
  logic                w_x_last;
  logic [X_W-1:0]      w_nx;
  logic [Y_W-1:0]      w_ny;
  logic                w_plot;
  logic [COLOUR_W-1:0] w_src_colour;
  logic [1:0]          w_src_mode;
  logic [COLOUR_W-1:0] w_pix;

  // Sums are one bit wider than the stored end values so the clamp never
  // sees a wrapped result.
  always_comb begin
    w_x_sum    = {2'b00, bus.x0} + {1'b0, bus.w};
    w_y_sum    = {2'b00, bus.y0} + {1'b0, bus.h};
    w_x_end_ld = (w_x_sum > LP_SW) ? LP_SW[X_W:0] : w_x_sum[X_W:0];
    w_y_end_ld = (w_y_sum > LP_SH) ? LP_SH : w_y_sum;
    w_empty    = (bus.w == '0) || (bus.h == '0) ||
                 ({2'b00, bus.x0} >= LP_SW) || ({2'b00, bus.y0} >= LP_SH);
    w_x_inc    = {1'b0, r_vga_x} + (X_W+1)'(1);
    w_y_inc    = {2'b00, r_vga_y} + (Y_W+2)'(1);
    w_y_wrap   = (w_y_inc == r_y_end);
    w_x_last   = (w_x_inc == r_x_end);
  end

  // Next state and next pixel. The pixel registers double as the scan
  // counters: the pixel being shown is the current scan position.
  always_comb begin
    w_next       = r_state;
    w_nx         = r_vga_x;
    w_ny         = r_vga_y;
    w_plot       = 1'b0;
    w_src_colour = r_colour;
    w_src_mode   = r_mode;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_LOAD;
      end
      S_LOAD: begin
        // Colour/mode are latched on this edge, so the first pixel uses
        // the live inputs.
        w_src_colour = bus.colour;
        w_src_mode   = bus.mode;
        if (w_empty) begin
          w_next = S_DONE;
        end else begin
          w_next = S_FILL;
          w_nx   = bus.x0;
          w_ny   = bus.y0;
          w_plot = 1'b1;
        end
      end
      S_FILL: begin
        if (bus.abort || (w_y_wrap && w_x_last)) begin
          w_next = S_DONE;
        end else begin
          w_plot = 1'b1;
          if (w_y_wrap) begin
            w_ny = r_y0;
            w_nx = w_x_inc[X_W-1:0];
          end else begin
            w_ny = w_y_inc[Y_W-1:0];
          end
        end
      end
      S_DONE: begin
        if (!bus.start) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    case (w_src_mode)
      2'd0:    w_pix = w_src_colour;
      2'd1:    w_pix = w_nx[COLOUR_W-1:0];
      2'd2:    w_pix = (w_nx[0] ^ w_ny[0]) ? ~w_src_colour : w_src_colour;
      default: w_pix = w_ny[COLOUR_W-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_x_end      <= '0;
      r_y_end      <= '0;
      r_y0         <= '0;
      r_colour     <= '0;
      r_mode       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next == S_LOAD) || (w_next == S_FILL);
      r_done     <= (w_next == S_DONE);
      r_vga_plot <= w_plot;
      if (w_plot) begin
        r_vga_x      <= w_nx;
        r_vga_y      <= w_ny;
        r_vga_colour <= w_pix;
      end
      if (r_state == S_LOAD) begin
        r_colour <= bus.colour;
        r_mode   <= bus.mode;
        r_y0     <= bus.y0;
        r_x_end  <= w_x_end_ld;
        r_y_end  <= w_y_end_ld;
      end
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_vga_colour;
  assign bus.vga_plot   = r_vga_plot;

endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rect_fill_engine_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(C_W)) bus ();

  rect_fill_engine #(
    .SCREEN_W(160), .SCREEN_H(120), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(C_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input int x0, input int y0, input int w, input int h,
                       input int colour, input int mode);
    bus.x0     = X_W'(x0);
    bus.y0     = Y_W'(y0);
    bus.w      = (X_W+1)'(w);
    bus.h      = (Y_W+1)'(h);
    bus.colour = C_W'(colour);
    bus.mode   = 2'(mode);
  endtask

  task automatic end_op;
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    setup(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b plot=%b x=%0d y=%0d c=%0d, required all 0",
               bus.busy, bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.vga_plot} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b plot=%b, required 000",
               bus.busy, bus.done, bus.vga_plot);
    end
  endtask

  task automatic test_full_screen;
    int bad = 0;
    setup(0, 0, 160, 120, 0, 1);
    bus.start = 1'b1;
    tick();
    checks++;
    if ({bus.busy, bus.vga_plot} !== 2'b10) begin
      errors++;
      $display("FAIL full_load_cycle: busy=%b plot=%b, required busy=1 plot=0", bus.busy, bus.vga_plot);
    end
    for (int i = 0; i < 19200; i++) begin
      int ex = i / 120;
      int ey = i % 120;
      tick();
      if (i == 0) begin
        checks++;
        if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== {1'b1, 8'd0, 7'd0, 3'd0}) begin
          errors++;
          $display("FAIL full_first_pixel: plot=%b (%0d,%0d) c=%0d, required plot=1 (0,0) c=0",
                   bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
        end
      end
      if (i == 19199) begin
        checks++;
        if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== {1'b1, 8'd159, 7'd119, 3'd7}) begin
          errors++;
          $display("FAIL full_last_pixel: plot=%b (%0d,%0d) c=%0d, required plot=1 (159,119) c=7",
                   bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
        end
      end
      if ({bus.vga_plot, bus.busy, bus.done, bus.vga_x, bus.vga_y, bus.vga_colour} !==
          {1'b1, 1'b1, 1'b0, 8'(ex), 7'(ey), 3'(ex % 8)}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL full_scan: %0d wrong pixel cycles, required 0", bad);
    end
    tick();
    checks++;
    if ({bus.vga_plot, bus.busy, bus.done} !== 3'b001) begin
      errors++;
      $display("FAIL full_done: plot=%b busy=%b done=%b, required 0 0 1",
               bus.vga_plot, bus.busy, bus.done);
    end
    end_op();
  endtask

  task automatic test_small_rect;
    int ex[6] = '{10, 10, 11, 11, 12, 12};
    int ey[6] = '{20, 21, 20, 21, 20, 21};
    setup(10, 20, 3, 2, 5, 0);
    bus.start = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== {1'b1, 8'(ex[i]), 7'(ey[i]), 3'd5}) begin
        errors++;
        $display("FAIL small_pixel%0d: plot=%b (%0d,%0d) c=%0d, required plot=1 (%0d,%0d) c=5",
                 i, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, ex[i], ey[i]);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bus.done, bus.busy, bus.vga_plot, bus.vga_x, bus.vga_y} !== {3'b100, 8'd12, 7'd21}) begin
        errors++;
        $display("FAIL small_done_hold%0d: done=%b busy=%b plot=%b (%0d,%0d), required done=1 (12,21)",
                 k, bus.done, bus.busy, bus.vga_plot, bus.vga_x, bus.vga_y);
      end
      tick();
    end
    end_op();
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL small_done_drop: done=%b busy=%b, required 00", bus.done, bus.busy);
    end
  endtask

  task automatic test_clipping;
    int ex[4] = '{158, 158, 159, 159};
    int ey[4] = '{118, 119, 118, 119};
    setup(158, 118, 5, 5, 2, 0);
    bus.start = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== {1'b1, 8'(ex[i]), 7'(ey[i]), 3'd2}) begin
        errors++;
        $display("FAIL clip_pixel%0d: plot=%b (%0d,%0d) c=%0d, required plot=1 (%0d,%0d) c=2",
                 i, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, ex[i], ey[i]);
      end
      tick();
    end
    checks++;
    if ({bus.vga_plot, bus.done} !== 2'b01) begin
      errors++;
      $display("FAIL clip_done: plot=%b done=%b, required 0 1", bus.vga_plot, bus.done);
    end
    end_op();

    for (int c = 0; c < 2; c++) begin
      if (c == 0) setup(20, 20, 0, 5, 1, 0);
      else        setup(200, 20, 5, 5, 1, 0);
      bus.start = 1'b1;
      tick();
      checks++;
      if ({bus.busy, bus.done, bus.vga_plot} !== 3'b100) begin
        errors++;
        $display("FAIL empty%0d_load: busy=%b done=%b plot=%b, required 1 0 0",
                 c, bus.busy, bus.done, bus.vga_plot);
      end
      tick();
      checks++;
      if ({bus.busy, bus.done, bus.vga_plot, bus.vga_x, bus.vga_y} !== {3'b010, 8'd159, 7'd119}) begin
        errors++;
        $display("FAIL empty%0d_done: busy=%b done=%b plot=%b (%0d,%0d), required 0 1 0 (159,119)",
                 c, bus.busy, bus.done, bus.vga_plot, bus.vga_x, bus.vga_y);
      end
      end_op();
    end
  endtask

  task automatic test_checker;
    int ec[4] = '{3, 4, 4, 3};
    setup(0, 0, 2, 2, 3, 2);
    bus.start = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== {1'b1, 8'(i / 2), 7'(i % 2), 3'(ec[i])}) begin
        errors++;
        $display("FAIL checker_pixel%0d: plot=%b (%0d,%0d) c=%0d, required plot=1 (%0d,%0d) c=%0d",
                 i, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, i / 2, i % 2, ec[i]);
      end
      tick();
    end
    end_op();
  endtask

  task automatic test_abort;
    int plots = 0;
    setup(0, 0, 160, 120, 6, 0);
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.vga_plot === 1'b1) plots++;
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.vga_plot === 1'b1) plots++;
      if (k == 0) begin
        checks++;
        if ({bus.vga_plot, bus.busy, bus.done, bus.vga_x, bus.vga_y} !== {3'b001, 8'd0, 7'd2}) begin
          errors++;
          $display("FAIL abort_stop: plot=%b busy=%b done=%b (%0d,%0d), required 0 0 1 (0,2)",
                   bus.vga_plot, bus.busy, bus.done, bus.vga_x, bus.vga_y);
        end
      end
      tick();
    end
    checks++;
    if (plots !== 3) begin
      errors++;
      $display("FAIL abort_count: %0d plots, required 3", plots);
    end
    end_op();

    // Restart; abort held through IDLE and the LOAD edge must be ignored.
    setup(3, 4, 2, 2, 1, 3);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    tick();
    bus.abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !==
          {1'b1, 8'(3 + i / 2), 7'(4 + i % 2), 3'(4 + i % 2)}) begin
        errors++;
        $display("FAIL restart_pixel%0d: plot=%b (%0d,%0d) c=%0d, required plot=1 (%0d,%0d) c=%0d",
                 i, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, 3 + i / 2, 4 + i % 2, 4 + i % 2);
      end
      tick();
    end
    checks++;
    if ({bus.vga_plot, bus.done} !== 2'b01) begin
      errors++;
      $display("FAIL restart_done: plot=%b done=%b, required 0 1", bus.vga_plot, bus.done);
    end
    end_op();
  endtask

  task automatic test_reset_mid_fill;
    setup(5, 6, 4, 4, 0, 3);
    bus.start = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== {1'b1, 8'd5, 7'd7, 3'd7}) begin
      errors++;
      $display("FAIL midfill_pixel: plot=%b (%0d,%0d) c=%0d, required plot=1 (5,7) c=7",
               bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== '0) begin
      errors++;
      $display("FAIL midfill_reset: busy=%b done=%b plot=%b x=%0d y=%0d c=%0d, required all 0",
               bus.busy, bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
    end
    tick();
    checks++;
    if ({bus.busy, bus.vga_plot} !== 2'b10) begin
      errors++;
      $display("FAIL midfill_reload: busy=%b plot=%b, required busy=1 plot=0", bus.busy, bus.vga_plot);
    end
    tick();
    checks++;
    if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== {1'b1, 8'd5, 7'd6, 3'd6}) begin
      errors++;
      $display("FAIL midfill_restart: plot=%b (%0d,%0d) c=%0d, required plot=1 (5,6) c=6",
               bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
    end
    end_op();
  endtask

  initial begin
    test_reset();
    test_full_screen();
    test_small_rect();
    test_clipping();
    test_checker();
    test_abort();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
